cue_sequencer: RTL and testbench

CUE_SEQUENCER -- requirements
Module: cue_sequencer

---
 rtl/cue_sequencer.sv | 138 +++++++++++++
 tb/tb_cue_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cue_sequencer.sv
// Records {music address, mole location} cues into a small table, then replays them
// as one-cycle request_mole pulses when the playback address reaches each cue.
module cue_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 23,
    parameter int LW    = 3,
    parameter int LOOP  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mode_record,
    input  logic                         mode_play,
    input  logic                         clear,
    input  logic                         rec_strobe,
    input  logic [LW-1:0]                rec_location,
    input  logic [AW-1:0]                music_address,
    output logic                         request_mole,
    output logic [LW-1:0]                mole_location,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         overflow,
    output logic                         rejected,
    output logic [1:0]                   seq_state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] loc;
    } entry_t;

    state_t        state;
    entry_t        cue_table [DEPTH];
    logic [CW-1:0] index;
    logic [AW-1:0] last_addr;
    entry_t        cur_entry;
    logic [AW-1:0] first_addr;
    logic          accept;
    logic          wr_en;
    logic          empty_on_entry;

    // Cues must be strictly increasing so playback can walk the table in order.
    assign accept         = (count == '0) || (music_address > last_addr);
    assign full           = (count == CW'(DEPTH));
    assign wr_en          = (state == RECORD) && rec_strobe && !full && accept;
    assign empty_on_entry = clear || (count == '0);
    assign cur_entry      = cue_table[index[IW-1:0]];
    assign first_addr     = cue_table[0].addr;
    assign done           = (state == DONE);
    assign seq_state      = state;

    // NOTE: the cue table has no reset; entries at or above count are never read as valid,
    // so leaving them out of reset keeps the storage mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            cue_table[count[IW-1:0]] <= '{addr: music_address, loc: rec_location};
        end
    end

    // NOTE: all state below uses non-blocking assignments so every branch sees the
    // pre-edge values of count, index and state regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            index         <= '0;
            request_mole  <= 1'b0;
            mole_location <= '0;
            overflow      <= 1'b0;
            rejected      <= 1'b0;
        end else begin
            request_mole <= 1'b0;
            rejected     <= 1'b0;
            case (state)
                IDLE: begin
                    index <= '0;
                    if (clear) begin
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                    if (mode_record) begin
                        state <= RECORD;
                    end else if (mode_play) begin
                        state <= (empty_on_entry && LOOP == 0) ? DONE : PLAY;
                    end
                end
                RECORD: begin
                    // A strobe on the exit edge is still honoured.
                    if (rec_strobe) begin
                        if (full) begin
                            overflow <= 1'b1;
                        end else if (accept) begin
                            count     <= count + CW'(1);
                            last_addr <= music_address;
                        end else begin
                            rejected <= 1'b1;
                        end
                    end
                    if (!mode_record) state <= IDLE;
                end
                PLAY: begin
                    if (!mode_play) begin
                        state <= IDLE;
                        index <= '0;
                    end else if (index < count) begin
                        if (music_address >= cur_entry.addr) begin
                            request_mole  <= 1'b1;
                            mole_location <= cur_entry.loc;
                            index         <= index + CW'(1);
                            if (index + CW'(1) == count && LOOP == 0) state <= DONE;
                        end
                    end else if (LOOP != 0 && count != '0 && music_address < first_addr) begin
                        // Song restarted: re-arm from the first cue.
                        index <= '0;
                    end
                end
                DONE: begin
                    if (!mode_play) begin
                        state <= IDLE;
                        index <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cue_sequencer.sv
// Directed bench for cue_sequencer: three instances (default, DEPTH=4, LOOP=1) share stimulus.
module tb_cue_sequencer;

    logic        clk;
    logic        reset;
    logic        mode_record;
    logic        mode_play;
    logic        clear;
    logic        rec_strobe;
    logic [2:0]  rec_location;
    logic [22:0] music_address;

    logic        m_request_mole, s_request_mole, l_request_mole;
    logic [2:0]  m_mole_location, s_mole_location, l_mole_location;
    logic        m_done, s_done, l_done;
    logic [4:0]  m_count, l_count;
    logic [2:0]  s_count;
    logic        m_full, s_full, l_full;
    logic        m_overflow, s_overflow, l_overflow;
    logic        m_rejected, s_rejected, l_rejected;
    logic [1:0]  m_seq_state, s_seq_state, l_seq_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [22:0] cue_addr [3] = '{23'h100, 23'h200, 23'h300};
    logic [2:0]  cue_loc  [3] = '{3'd1, 3'd5, 3'd7};
    logic [22:0] lcue_addr [2] = '{23'h100, 23'h200};
    logic [2:0]  lcue_loc  [2] = '{3'd3, 3'd4};

    cue_sequencer #(.DEPTH(16), .AW(23), .LW(3), .LOOP(0)) u_main (
        .clk(clk), .reset(reset), .mode_record(mode_record), .mode_play(mode_play),
        .clear(clear), .rec_strobe(rec_strobe), .rec_location(rec_location),
        .music_address(music_address), .request_mole(m_request_mole),
        .mole_location(m_mole_location), .done(m_done), .count(m_count), .full(m_full),
        .overflow(m_overflow), .rejected(m_rejected), .seq_state(m_seq_state)
    );

    cue_sequencer #(.DEPTH(4), .AW(23), .LW(3), .LOOP(0)) u_small (
        .clk(clk), .reset(reset), .mode_record(mode_record), .mode_play(mode_play),
        .clear(clear), .rec_strobe(rec_strobe), .rec_location(rec_location),
        .music_address(music_address), .request_mole(s_request_mole),
        .mole_location(s_mole_location), .done(s_done), .count(s_count), .full(s_full),
        .overflow(s_overflow), .rejected(s_rejected), .seq_state(s_seq_state)
    );

    cue_sequencer #(.DEPTH(16), .AW(23), .LW(3), .LOOP(1)) u_loop (
        .clk(clk), .reset(reset), .mode_record(mode_record), .mode_play(mode_play),
        .clear(clear), .rec_strobe(rec_strobe), .rec_location(rec_location),
        .music_address(music_address), .request_mole(l_request_mole),
        .mole_location(l_mole_location), .done(l_done), .count(l_count), .full(l_full),
        .overflow(l_overflow), .rejected(l_rejected), .seq_state(l_seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mode_record = 1'b0; mode_play = 1'b0; clear = 1'b0;
        rec_strobe = 1'b0; rec_location = '0; music_address = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic record_cue(input logic [22:0] a, input logic [2:0] l);
        music_address = a; rec_location = l; rec_strobe = 1'b1;
        tick();
        rec_strobe = 1'b0;
    endtask

    task automatic record_three();
        mode_record = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) record_cue(cue_addr[i], cue_loc[i]);
        mode_record = 1'b0;
        tick();
        music_address = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode_record = 1'b1; mode_play = 1'b1; rec_strobe = 1'b1;
        clear = 1'b0; rec_location = 3'd6; music_address = 23'h50;
        tick();
        n_checks++; if (m_seq_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", m_seq_state); end
        n_checks++; if (m_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", m_count); end
        n_checks++; if (m_request_mole !== 1'b0 || m_done !== 1'b0) begin n_fail++; $display("FAIL reset_pulse_done: got %b%b want 00", m_request_mole, m_done); end
        n_checks++; if (m_overflow !== 1'b0 || m_rejected !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", m_overflow, m_rejected); end
        n_checks++; if (m_mole_location !== 3'd0 || m_full !== 1'b0) begin n_fail++; $display("FAIL reset_loc_full: got %0d/%b want 0/0", m_mole_location, m_full); end
        reset = 1'b0; mode_record = 1'b0; mode_play = 1'b0; rec_strobe = 1'b0;
        tick();
    endtask

    task automatic test_record_play();
        int  exp_idx;
        int  pulses;
        logic exp;
        do_reset();
        mode_record = 1'b1;
        tick();
        n_checks++; if (m_seq_state !== 2'd1) begin n_fail++; $display("FAIL enter_record: got %0d want 1", m_seq_state); end
        for (int i = 0; i < 3; i++) record_cue(cue_addr[i], cue_loc[i]);
        n_checks++; if (m_count !== 5'd3) begin n_fail++; $display("FAIL record_count: got %0d want 3", m_count); end
        mode_record = 1'b0;
        tick();
        n_checks++; if (m_seq_state !== 2'd0) begin n_fail++; $display("FAIL exit_record: got %0d want 0", m_seq_state); end
        music_address = '0; mode_play = 1'b1;
        tick();
        n_checks++; if (m_seq_state !== 2'd2) begin n_fail++; $display("FAIL enter_play: got %0d want 2", m_seq_state); end
        exp_idx = 0; pulses = 0;
        for (int a = 0; a <= 'h400; a += 'h40) begin
            music_address = 23'(a);
            tick();
            exp = (exp_idx < 3) && (23'(a) >= cue_addr[exp_idx]);
            n_checks++; if (m_request_mole !== exp) begin n_fail++; $display("FAIL ramp_pulse @%0h: got %b want %b", a, m_request_mole, exp); end
            if (exp) begin
                n_checks++; if (m_mole_location !== cue_loc[exp_idx]) begin n_fail++; $display("FAIL ramp_loc @%0h: got %0d want %0d", a, m_mole_location, cue_loc[exp_idx]); end
                exp_idx++;
            end
            if (m_request_mole === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL ramp_pulse_total: got %0d want 3", pulses); end
        n_checks++; if (m_done !== 1'b1 || m_seq_state !== 2'd3) begin n_fail++; $display("FAIL ramp_done: got done=%b state=%0d want 1/3", m_done, m_seq_state); end
        tick();
        n_checks++; if (m_mole_location !== 3'd7) begin n_fail++; $display("FAIL loc_hold: got %0d want 7", m_mole_location); end
        mode_play = 1'b0;
        tick();
        n_checks++; if (m_seq_state !== 2'd0 || m_done !== 1'b0) begin n_fail++; $display("FAIL play_exit: got state=%0d done=%b want 0/0", m_seq_state, m_done); end
    endtask

    task automatic test_overflow();
        do_reset();
        mode_record = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) record_cue(23'(i * 'h10), 3'(i));
        n_checks++; if (s_count !== 3'd4 || s_full !== 1'b1) begin n_fail++; $display("FAIL fill_to_depth: got count=%0d full=%b want 4/1", s_count, s_full); end
        n_checks++; if (s_overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_early: got %b want 0", s_overflow); end
        record_cue(23'h50, 3'd5);
        n_checks++; if (s_overflow !== 1'b1 || s_count !== 3'd4) begin n_fail++; $display("FAIL overflow_set: got ovf=%b count=%0d want 1/4", s_overflow, s_count); end
        mode_record = 1'b0;
        tick();
        n_checks++; if (s_overflow !== 1'b1 || s_seq_state !== 2'd0) begin n_fail++; $display("FAIL overflow_sticky: got ovf=%b state=%0d want 1/0", s_overflow, s_seq_state); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++; if (s_count !== 3'd0 || s_overflow !== 1'b0 || s_full !== 1'b0) begin n_fail++; $display("FAIL clear: got count=%0d ovf=%b full=%b want 0/0/0", s_count, s_overflow, s_full); end
    endtask

    task automatic test_reject();
        do_reset();
        mode_record = 1'b1;
        tick();
        record_cue(23'h200, 3'd2);
        record_cue(23'h150, 3'd3);
        n_checks++; if (m_rejected !== 1'b1 || m_count !== 5'd1) begin n_fail++; $display("FAIL reject_lower: got rej=%b count=%0d want 1/1", m_rejected, m_count); end
        tick();
        n_checks++; if (m_rejected !== 1'b0) begin n_fail++; $display("FAIL reject_one_cycle: got %b want 0", m_rejected); end
        record_cue(23'h200, 3'd4);
        n_checks++; if (m_rejected !== 1'b1 || m_count !== 5'd1) begin n_fail++; $display("FAIL reject_equal: got rej=%b count=%0d want 1/1", m_rejected, m_count); end
        record_cue(23'h201, 3'd4);
        n_checks++; if (m_rejected !== 1'b0 || m_count !== 5'd2) begin n_fail++; $display("FAIL accept_higher: got rej=%b count=%0d want 0/2", m_rejected, m_count); end
        mode_record = 1'b0;
        record_cue(23'h300, 3'd6);
        n_checks++; if (m_count !== 5'd3 || m_seq_state !== 2'd0) begin n_fail++; $display("FAIL exit_edge_strobe: got count=%0d state=%0d want 3/0", m_count, m_seq_state); end
    endtask

    task automatic test_jump();
        do_reset();
        record_three();
        mode_play = 1'b1;
        tick();
        music_address = 23'h400;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (m_request_mole !== 1'b1 || m_mole_location !== cue_loc[i]) begin n_fail++; $display("FAIL jump_cue%0d: got pulse=%b loc=%0d want 1/%0d", i, m_request_mole, m_mole_location, cue_loc[i]); end
        end
        tick();
        n_checks++; if (m_request_mole !== 1'b0 || m_done !== 1'b1) begin n_fail++; $display("FAIL jump_after: got pulse=%b done=%b want 0/1", m_request_mole, m_done); end
        mode_play = 1'b0;
        tick();
    endtask

    task automatic test_loop();
        int   idx;
        int   pulses;
        logic done_seen;
        logic exp;
        do_reset();
        mode_record = 1'b1;
        tick();
        record_cue(lcue_addr[0], lcue_loc[0]);
        record_cue(lcue_addr[1], lcue_loc[1]);
        mode_record = 1'b0;
        tick();
        music_address = '0; mode_play = 1'b1;
        tick();
        n_checks++; if (l_seq_state !== 2'd2) begin n_fail++; $display("FAIL loop_enter: got %0d want 2", l_seq_state); end
        idx = 0; pulses = 0; done_seen = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int a = 0; a <= 'h400; a += 'h40) begin
                music_address = 23'(a);
                tick();
                exp = 1'b0;
                if (idx < 2) begin
                    if (23'(a) >= lcue_addr[idx]) exp = 1'b1;
                end else if (23'(a) < lcue_addr[0]) begin
                    idx = 0;
                end
                n_checks++; if (l_request_mole !== exp) begin n_fail++; $display("FAIL loop_pulse p%0d @%0h: got %b want %b", pass, a, l_request_mole, exp); end
                if (exp) begin
                    n_checks++; if (l_mole_location !== lcue_loc[idx]) begin n_fail++; $display("FAIL loop_loc p%0d @%0h: got %0d want %0d", pass, a, l_mole_location, lcue_loc[idx]); end
                    idx++;
                end
                if (l_request_mole === 1'b1) pulses++;
                if (l_done !== 1'b0) done_seen = 1'b1;
            end
        end
        n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL loop_total: got %0d want 4", pulses); end
        n_checks++; if (done_seen !== 1'b0 || l_seq_state !== 2'd2) begin n_fail++; $display("FAIL loop_no_done: got done_seen=%b state=%0d want 0/2", done_seen, l_seq_state); end
        mode_play = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_play();
        int pulses;
        do_reset();
        record_three();
        mode_play = 1'b1;
        tick();
        music_address = 23'h100;
        tick();
        n_checks++; if (m_request_mole !== 1'b1 || m_mole_location !== 3'd1) begin n_fail++; $display("FAIL midplay_first: got pulse=%b loc=%0d want 1/1", m_request_mole, m_mole_location); end
        reset = 1'b1;
        tick();
        n_checks++; if (m_seq_state !== 2'd0 || m_count !== 5'd0) begin n_fail++; $display("FAIL midplay_reset: got state=%0d count=%0d want 0/0", m_seq_state, m_count); end
        n_checks++; if (m_request_mole !== 1'b0 || m_mole_location !== 3'd0) begin n_fail++; $display("FAIL midplay_reset_out: got pulse=%b loc=%0d want 0/0", m_request_mole, m_mole_location); end
        reset = 1'b0;
        tick();
        n_checks++; if (m_seq_state !== 2'd3 || m_done !== 1'b1) begin n_fail++; $display("FAIL empty_play: got state=%0d done=%b want 3/1", m_seq_state, m_done); end
        music_address = 23'h400;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (m_request_mole !== 1'b0) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL empty_no_pulse: got %0d pulses want 0", pulses); end
        mode_play = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; mode_record = 1'b0; mode_play = 1'b0; clear = 1'b0;
        rec_strobe = 1'b0; rec_location = '0; music_address = '0;
        test_reset();
        test_record_play();
        test_overflow();
        test_reject();
        test_jump();
        test_loop();
        test_reset_mid_play();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
